// File: rtl/fifo1_width_serializer.sv
// Serializes one wide element from a single-entry upstream FIFO into
// BEAT_WIDTH-wide beats, least-significant beat first. Both sides use the
// ENA/RDY method handshake; the next element is captured on the last beat's
// consume cycle so consecutive elements stream without a bubble.
module fifo1_width_serializer #(
    parameter int DATA_WIDTH = 704,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] in_first,
    input  logic                  in_first_rdy,
    input  logic                  in_deq_rdy,
    output logic                  in_deq_ena,
    output logic [BEAT_WIDTH-1:0] out_first,
    output logic                  out_first_rdy,
    output logic                  out_last,
    input  logic                  out_deq_ena,
    output logic                  out_deq_rdy
);

    localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         cnt_s;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic [DATA_WIDTH-1:0] shreg_s;
    logic                  deq_s;
    logic                  load_ok_s;
    logic                  last_s;
    logic                  in_deq_ena_s;

    // Next-state, next-shift-register and upstream dequeue decision.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        shreg_s      = shreg_r;
        in_deq_ena_s = 1'b0;
        deq_s        = out_deq_ena && (state_r == BUSY);
        load_ok_s    = in_first_rdy && in_deq_rdy && !RST;
        last_s       = (state_r == BUSY) && (cnt_r == LAST_CNT);
        case (state_r)
            IDLE: begin
                if (load_ok_s) begin
                    in_deq_ena_s = 1'b1;
                    shreg_s      = in_first;
                    cnt_s        = {CW{1'b0}};
                    state_s      = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (deq_s) begin
                    if (last_s) begin
                        if (load_ok_s) begin
                            // Chain straight into the next element.
                            in_deq_ena_s = 1'b1;
                            shreg_s      = in_first;
                            cnt_s        = {CW{1'b0}};
                            state_s      = BUSY;
                        end else begin
                            cnt_s   = {CW{1'b0}};
                            state_s = IDLE;
                        end
                    end else begin
                        shreg_s = shreg_r >> BEAT_WIDTH;
                        cnt_s   = cnt_r + CW'(1);
                    end
                end else begin
                    // Backpressure: hold the current beat.
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, beat counter and shift register with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            shreg_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shreg_r <= shreg_s;
        end
    end

    assign in_deq_ena    = in_deq_ena_s;
    assign out_first     = shreg_r[BEAT_WIDTH-1:0];
    assign out_first_rdy = (state_r == BUSY);
    assign out_deq_rdy   = (state_r == BUSY);
    assign out_last      = last_s;

endmodule

// File: tb/tb_fifo1_width_serializer.sv
// Self-checking bench for fifo1_width_serializer: a directed vector table,
// hand-written multi-cycle sequences and a randomized phase checked against
// a beat-queue reference model.
module tb_fifo1_width_serializer;

    localparam int DW    = 704;
    localparam int BW    = 32;
    localparam int BEATS = DW / BW;

    logic          CLK;
    logic          rst;
    logic [DW-1:0] in_first;
    logic          in_first_rdy;
    logic          in_deq_rdy;
    logic          in_deq_ena;
    logic [BW-1:0] out_first;
    logic          out_first_rdy;
    logic          out_last;
    logic          out_deq_ena;
    logic          out_deq_rdy;

    int checks;
    int errors;

    // Reference model: beats still owed downstream, oldest first.
    logic [BW-1:0] q[$];

    typedef struct {
        logic          rst;
        logic          fr;
        logic          dr;
        logic          od;
        logic [DW-1:0] data;
        logic          exp_ena;
        logic          exp_rdy;
        logic          exp_last;
        logic [BW-1:0] exp_first;
    } vec_t;

    vec_t vecs[$];

    fifo1_width_serializer #(.DATA_WIDTH(DW), .BEAT_WIDTH(BW)) dut (
        .CLK           (CLK),
        .RST           (rst),
        .in_first      (in_first),
        .in_first_rdy  (in_first_rdy),
        .in_deq_rdy    (in_deq_rdy),
        .in_deq_ena    (in_deq_ena),
        .out_first     (out_first),
        .out_first_rdy (out_first_rdy),
        .out_last      (out_last),
        .out_deq_ena   (out_deq_ena),
        .out_deq_rdy   (out_deq_rdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] counting_elem(input logic [31:0] base);
        logic [DW-1:0] e;
        for (int k = 0; k < BEATS; k++) e[k*BW +: BW] = base + 32'(k);
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_elem();
        logic [DW-1:0] e;
        for (int k = 0; k < BEATS; k++) e[k*BW +: BW] = $urandom;
        return e;
    endfunction

    // One clock cycle against the model: inputs already driven, compare, then edge.
    task automatic cycle(output logic ena_seen, output logic deq_seen);
        logic busy, dq, lo, exp_ena;
        #2;
        busy    = (q.size() != 0);
        dq      = out_deq_ena && busy;
        lo      = in_first_rdy && in_deq_rdy && !rst;
        exp_ena = lo && (!busy || (dq && q.size() == 1));
        if (rst) begin
            chk("rst_ena",   32'(in_deq_ena),    32'd0);
            chk("rst_rdy",   32'(out_first_rdy), 32'd0);
            chk("rst_first", 32'(out_first),     32'd0);
        end else begin
            chk("ena",     32'(in_deq_ena),    32'(exp_ena));
            chk("rdy",     32'(out_first_rdy), 32'(busy));
            chk("deq_rdy", 32'(out_deq_rdy),   32'(busy));
            chk("last",    32'(out_last),      32'(busy && q.size() == 1));
            if (busy) chk("first", 32'(out_first), 32'(q[0]));
        end
        ena_seen = exp_ena && !rst;
        deq_seen = dq && !rst;
        @(posedge CLK);
        if (rst) begin
            q.delete();
        end else begin
            if (dq) void'(q.pop_front());
            if (exp_ena) for (int k = 0; k < BEATS; k++) q.push_back(in_first[k*BW +: BW]);
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic fr, input logic dr, input logic od,
                         input logic [DW-1:0] d);
        rst = r; in_first_rdy = fr; in_deq_rdy = dr; out_deq_ena = od; in_first = d;
    endtask

    initial begin
        logic [DW-1:0] ea, eb, ec;
        logic          e_s, d_s;
        int            enas, deqs;
        vec_t          v;

        checks = 0;
        errors = 0;
        ea = counting_elem(32'h0000_0000);
        eb = counting_elem(32'hA500_0000);

        // Directed table: reset, single element, spurious ENA, reload at beat 0.
        for (int i = 0; i < 3; i++) begin
            v = '{1'b1, 1'b1, 1'b1, 1'b0, ea, 1'b0, 1'b0, 1'b0, 32'd0};
            vecs.push_back(v);
        end
        v = '{1'b0, 1'b1, 1'b1, 1'b0, ea, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs.push_back(v);
        for (int k = 0; k < BEATS; k++) begin
            v = '{1'b0, 1'b0, 1'b0, 1'b1, ea, 1'b0, 1'b1, (k == BEATS-1), 32'(k)};
            vecs.push_back(v);
        end
        for (int i = 0; i < 2; i++) begin
            v = '{1'b0, 1'b0, 1'b0, 1'b1, ea, 1'b0, 1'b0, 1'b0, 32'd0};
            vecs.push_back(v);
        end
        v = '{1'b0, 1'b1, 1'b1, 1'b0, eb, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs.push_back(v);
        for (int k = 0; k < BEATS; k++) begin
            v = '{1'b0, 1'b0, 1'b0, 1'b1, eb, 1'b0, 1'b1, (k == BEATS-1),
                  32'hA500_0000 + 32'(k)};
            vecs.push_back(v);
        end

        drive(1'b1, 1'b1, 1'b1, 1'b0, ea);
        @(posedge CLK);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].fr, vecs[i].dr, vecs[i].od, vecs[i].data);
            #2;
            chk($sformatf("vec%0d_ena", i),  32'(in_deq_ena),    32'(vecs[i].exp_ena));
            chk($sformatf("vec%0d_rdy", i),  32'(out_first_rdy), 32'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_last", i), 32'(out_last),      32'(vecs[i].exp_last));
            if (vecs[i].exp_rdy || vecs[i].rst)
                chk($sformatf("vec%0d_first", i), 32'(out_first), vecs[i].exp_first);
            @(posedge CLK);
            #1;
        end
        q.delete();

        // Backpressure: consume every third cycle.
        drive(1'b0, 1'b1, 1'b1, 1'b0, ea);
        cycle(e_s, d_s);
        drive(1'b0, 1'b0, 1'b0, 1'b0, ea);
        deqs = 0;
        for (int c = 0; c < 3 * BEATS + 3; c++) begin
            out_deq_ena = (c % 3 == 2);
            cycle(e_s, d_s);
            if (d_s) deqs++;
        end
        chk("bp_beats", 32'(deqs), 32'(BEATS));

        // Back-to-back: two elements, continuous consume.
        enas = 0;
        deqs = 0;
        drive(1'b0, 1'b1, 1'b1, 1'b1, ea);
        cycle(e_s, d_s);
        if (e_s) enas++;
        in_first = eb;
        for (int c = 0; c < 2 * BEATS; c++) begin
            if (c == BEATS) begin in_first_rdy = 1'b0; in_deq_rdy = 1'b0; end
            cycle(e_s, d_s);
            if (e_s) enas++;
            if (d_s) deqs++;
        end
        chk("b2b_enas", 32'(enas), 32'd2);
        chk("b2b_beats", 32'(deqs), 32'(2 * BEATS));
        chk("b2b_idle", 32'(out_first_rdy), 32'd0);

        // Reset mid-element: after beat 7 is consumed.
        ec = rand_elem();
        drive(1'b0, 1'b1, 1'b1, 1'b0, ec);
        cycle(e_s, d_s);
        drive(1'b0, 1'b0, 1'b0, 1'b1, ec);
        for (int c = 0; c < 8; c++) cycle(e_s, d_s);
        in_first_rdy = 1'b1;
        in_deq_rdy   = 1'b1;
        out_deq_ena  = 1'b0;
        rst          = 1'b1;
        #1;
        chk("async_rst_rdy",   32'(out_first_rdy), 32'd0);
        chk("async_rst_last",  32'(out_last),      32'd0);
        chk("async_rst_ena",   32'(in_deq_ena),    32'd0);
        chk("async_rst_first", 32'(out_first),     32'd0);
        #1;
        @(posedge CLK);
        q.delete();
        #1;
        cycle(e_s, d_s);
        ea = rand_elem();
        drive(1'b0, 1'b1, 1'b1, 1'b0, ea);
        cycle(e_s, d_s);
        drive(1'b0, 1'b0, 1'b0, 1'b0, ea);
        cycle(e_s, d_s);
        chk("post_rst_beat0", 32'(out_first), 32'(ea[BW-1:0]));

        // Randomized phase against the model.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), rand_elem());
            cycle(e_s, d_s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
